// File: rtl/timer_pkg.sv
// Shared definitions for the CPU-programmable down-counting timer:
// state encoding, register offsets, CTRL bit positions and mode codes.
package timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt; CTRL, PRESET and read-only COUNT on a 2-bit word offset.
module timer_dev
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_flag_q, irq_flag_d;
    state_e            state_q, state_d;

    logic ctrl_wr, preset_wr;
    logic unused_wdata;

    assign ctrl_wr      = sel & we & (addr == OFF_CTRL);
    assign preset_wr    = sel & we & (addr == OFF_PRESET);
    assign unused_wdata = ^wdata;

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        irq_flag_d = irq_flag_q;

        // A CPU write acknowledges the flag, but an expiry on the same edge
        // still raises it so no interrupt is lost.
        if (ctrl_wr || preset_wr)
            irq_flag_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_q[CTRL_EN])
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[CTRL_EN])
                    state_d = S_IDLE;
                else if (count_q > CNT_W'(1))
                    count_d = count_q - CNT_W'(1);
                else begin
                    count_d = '0;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                irq_flag_d = 1'b1;
                if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD)
                    state_d = S_LOAD;
                else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = S_IDLE;
                end
            end
        endcase

        // CPU writes override the FSM; disabling freezes COUNT where it is.
        if (ctrl_wr) begin
            ctrl_d = wdata[CTRL_W-1:0];
            if (!wdata[CTRL_EN]) begin
                state_d = S_IDLE;
                count_d = count_q;
            end
        end
        if (preset_wr)
            preset_d = wdata[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= S_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        case (addr)
            OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            OFF_PRESET: rdata = 32'(preset_q);
            OFF_COUNT:  rdata = 32'(count_q);
            default:    rdata = '0;
        endcase
    end

    assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Randomized bench for timer_dev: a timeline model (age since arming, count
// derived arithmetically) predicts irq and every register after each edge.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset, sel, we;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        irq;

    always #10 clk = ~clk;

    timer_dev #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: once armed, age 0 is the arming edge, age 1 samples
    // PRESET, COUNT follows from age by subtraction, expiry is handled one
    // edge after COUNT reaches zero.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count, m_load;
    bit          m_flag, m_active;
    longint      m_age;

    task automatic m_reset();
        m_ctrl = '0; m_preset = '0; m_count = '0; m_load = '0;
        m_flag = 0; m_active = 0; m_age = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input bit w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] cnt0;
        logic [3:0]  ctrl0;
        bit          int_edge;
        longint      lv, expire;
        cnt0 = m_count; ctrl0 = m_ctrl; int_edge = 0;
        if (!m_active) begin
            if (ctrl0[0]) begin m_active = 1; m_age = 0; end
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_load = m_preset; m_count = m_load; m_flag = 0;
            end else begin
                lv = longint'(m_load);
                expire = 1 + ((lv == 0) ? 1 : lv);
                if (m_age == expire + 1) begin
                    int_edge = 1; m_flag = 1;
                    if (ctrl0[2:1] == 2'b01) m_age = 0;
                    else begin m_active = 0; m_ctrl[0] = 1'b0; end
                end else
                    m_count = (m_age - 1 >= lv) ? 32'd0 : 32'(lv - (m_age - 1));
            end
        end
        if (w && a == 2'd0) begin
            m_ctrl = d[3:0];
            if (!d[0]) begin m_active = 0; m_count = cnt0; end
        end
        if (w && a == 2'd1) m_preset = d;
        if (w && (a == 2'd0 || a == 2'd1) && !int_edge) m_flag = 0;
    endtask

    logic [31:0] rd [4];
    logic        irq_s;

    task automatic check_all(input string pfx);
        chk({pfx, "_irq"}, {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
        irq_s = irq;
        for (int i = 0; i < 4; i++) begin
            addr = i[1:0];
            #1;
            rd[i] = rdata;
            chk($sformatf("%s_rd%0d", pfx, i), rdata, m_read(i[1:0]));
        end
    endtask

    task automatic cycle(input bit s, input bit wr, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = s; we = wr; addr = a; wdata = d;
        @(posedge clk);
        m_step(s && wr, a, d);
        #1;
        sel = 1'b0; we = 1'b0;
        check_all("cyc");
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b1, a, d);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    // Asserted between edges so the asynchronous clear is observed at once.
    task automatic do_reset();
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        check_all("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    int     hi_cnt;
    bit     found, any_irq;
    logic   rnd_en, rnd_im;
    logic [1:0]  rnd_a, rnd_mode;
    logic [31:0] rnd_d;
    bit     rnd_s, rnd_w;

    initial begin
        reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
        m_reset();
        #3;
        check_all("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // One-shot with IM: COUNT=5 after edge 2, 0 after edge 7, irq after 8.
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd0, 32'h9);
        for (int e = 1; e <= 10; e++) begin
            idle();
            if (e == 2) chk("os_cnt5", rd[2], 32'd5);
            if (e == 7) chk("os_cnt0", rd[2], 32'd0);
            if (e == 7) chk("os_irq_e7", {31'd0, irq_s}, 32'd0);
            if (e == 8) chk("os_irq_e8", {31'd0, irq_s}, 32'd1);
            if (e == 10) chk("os_irq_hold", {31'd0, irq_s}, 32'd1);
        end
        chk("os_ctrl", rd[0], 32'h8);
        wr_reg(2'd0, 32'h8);
        chk("os_ack", {31'd0, irq_s}, 32'd0);

        // Auto-reload N=3: pulses after edges 6, 11, 16.
        wr_reg(2'd1, 32'd3);
        wr_reg(2'd0, 32'hB);
        hi_cnt = 0;
        for (int e = 1; e <= 17; e++) begin
            idle();
            if (irq_s) hi_cnt++;
            if (e == 6 || e == 11 || e == 16)
                chk($sformatf("ar_pulse_e%0d", e), {31'd0, irq_s}, 32'd1);
            if (e == 7 || e == 12)
                chk($sformatf("ar_low_e%0d", e), {31'd0, irq_s}, 32'd0);
        end
        chk("ar_pulses", hi_cnt, 32'd3);
        wr_reg(2'd0, 32'h0);

        // Masked one-shot N=10: irq never rises, EN clears after edge 13.
        wr_reg(2'd1, 32'd10);
        wr_reg(2'd0, 32'h1);
        any_irq = 0;
        for (int e = 1; e <= 14; e++) begin
            idle();
            if (irq_s) any_irq = 1;
            if (e == 12) chk("mask_en_e12", rd[0], 32'h1);
            if (e == 13) chk("mask_en_e13", rd[0], 32'h0);
        end
        chk("mask_noirq", {31'd0, any_irq}, 32'd0);

        // Disable at COUNT=12 holds the count; re-enable reloads two edges later.
        wr_reg(2'd1, 32'd20);
        wr_reg(2'd0, 32'h1);
        found = 0;
        for (int e = 1; e <= 40 && !found; e++) begin
            idle();
            if (rd[2] == 32'd12) found = 1;
        end
        chk("hold_reach12", {31'd0, found}, 32'd1);
        wr_reg(2'd0, 32'h0);
        chk("hold_cnt_a", rd[2], 32'd12);
        idle(); idle();
        chk("hold_cnt_b", rd[2], 32'd12);
        wr_reg(2'd0, 32'h1);
        idle();
        chk("reen_e1", rd[2], 32'd12);
        idle();
        chk("reen_e2", rd[2], 32'd20);

        // Reset mid-run with irq high.
        wr_reg(2'd0, 32'h0);
        wr_reg(2'd1, 32'd5);
        wr_reg(2'd0, 32'h9);
        repeat (9) idle();
        chk("pre_rst_irq", {31'd0, irq_s}, 32'd1);
        do_reset();
        chk("rst_irq", {31'd0, irq_s}, 32'd0);
        chk("rst_cnt", rd[2], 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rnd_s = ($urandom_range(0, 4) == 0);
            rnd_w = rnd_s ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
            rnd_a = 2'($urandom_range(0, 3));
            rnd_en = ($urandom_range(0, 4) != 0);
            rnd_im = 1'($urandom_range(0, 1));
            rnd_mode = 2'($urandom_range(0, 3));
            if (rnd_a == 2'd0)
                rnd_d = ($urandom() & 32'hFFFF_FFF0) | {28'd0, rnd_im, rnd_mode, rnd_en};
            else if (rnd_a == 2'd1)
                rnd_d = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 12));
            else
                rnd_d = $urandom();
            cycle(rnd_s, rnd_w, rnd_a, rnd_d);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 SHALL have parameter: CNT_W, 32, counter/preset width (1..32); bits above CNT_W read as zero.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: sel  input  1  device select from CPU data-bus address decode.
REQ-005 SHALL have port: we  input  1  write strobe; a write occurs only when sel & we.
REQ-006 SHALL have port: addr  input  2  word offset (CPU address bits 3:2): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-007 SHALL have port: wdata  input  32  store data.
REQ-008 SHALL have port: rdata  output  32  load data, combinational from addr.
REQ-009 SHALL have port: irq  output  1  interrupt request to CPU.

Function
REQ-010 SHALL decode CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (irq mask); other bits read zero.
REQ-011 SHALL read CTRL, PRESET, COUNT at offsets 0/1/2; offset 3 reads 0; COUNT is read-only, writes to it are ignored.
REQ-012 SHALL implement FSM states IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if EN=1 go LOAD next edge; else stay, COUNT held.
REQ-014 LOAD: COUNT <= PRESET; go CNT.
REQ-015 CNT: if EN=0 go IDLE (COUNT held); else if COUNT>1 decrement; else COUNT <= 0, go INT.
REQ-016 INT mode 00: set irq_flag, clear EN, go IDLE.
REQ-017 INT mode 01: pulse irq_flag for exactly one cycle, go LOAD (EN stays 1).
REQ-018 irq SHALL equal irq_flag & IM.
REQ-019 Mode-00 irq_flag SHALL stay set until any CPU write to CTRL or PRESET.
REQ-020 Latency: with EN written 1 at edge 0 and PRESET=N>=1, COUNT=N after edge 2, state INT after edge 2+N, irq high after edge 3+N; PRESET=0 behaves as N=1.
REQ-021 Auto-reload period SHALL be N+2 cycles between irq pulses.
REQ-022 Simultaneous CPU CTRL write and FSM clearing EN in INT: CPU write wins.
REQ-023 PRESET write during CNT SHALL NOT affect the current count; it takes effect at next LOAD.
REQ-024 CTRL write with EN=0 during any state SHALL force IDLE at next edge; COUNT retained.

Reset
REQ-025 On reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state IDLE, irq=0; takes effect immediately and asynchronously, including mid-count.
REQ-026 rdata SHALL reflect reset register values while reset is high.

Structure
REQ-027 Shared package timer_pkg SHALL hold state encoding, register offsets, CTRL bit positions and mode codes.
REQ-028 Block SHALL be a single module; no sub-module.

Verification
REQ-029 PRESET=5, CTRL=0x9 at edge 0 -> COUNT reads 5 after edge 2, 0 after edge 7; irq rises after edge 8 and holds; CTRL.EN reads 0.
REQ-030 After REQ-029, write CTRL=0x8 -> irq low after that edge; state IDLE.
REQ-031 PRESET=3, CTRL=0xB (auto-reload, IM) at edge 0 -> one-cycle irq pulses after edges 6, 11, 16.
REQ-032 PRESET=10, CTRL=0x1 (IM=0) -> irq stays 0 throughout; CTRL.EN cleared after edge 13.
REQ-033 PRESET=20 counting, write CTRL=0x0 when COUNT=12 -> COUNT holds 12; re-enable -> reloads 20 two edges later.
REQ-034 Assert reset mid-count with irq high -> all registers, rdata and irq read 0 immediately, before next clock edge.
